// File: rtl/config_pkg.sv
// Shared configuration for the USB transmit arbiter: FSM state encoding,
// requester-count limits and pointer sizing.
package config_pkg;

  localparam int REQUESTERS_MIN = 2;
  localparam int REQUESTERS_MAX = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQUEST = 2'd1,
    ST_STREAM  = 2'd2,
    ST_DRAIN   = 2'd3
  } tx_state_e;

  // Width of a pointer able to index n requesters.
  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_priority_select.sv
// Combinational round-robin picker: the first requesting index at or after
// the pointer (wrapping) receives the one-hot grant.
module rr_priority_select
  import config_pkg::*;
#(
  parameter int N     = 2,
  parameter int PTR_W = ptr_width(N)
) (
  input  logic [N-1:0]     i_req,
  input  logic [PTR_W-1:0] i_ptr,
  output logic [N-1:0]     o_grant
);

  logic w_found;

  // Walk offsets 0..N-1 from the pointer; the first hit wins.
  always_comb begin
    o_grant = '0;
    w_found = 1'b0;
    for (int k = 0; k < N; k++) begin
      for (int j = 0; j < N; j++) begin
        if (!w_found && i_req[j] && (((int'(i_ptr) + k) % N) == j)) begin
          o_grant[j] = 1'b1;
          w_found    = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/usb_tx_arbiter.sv
// Packet-atomic round-robin arbiter sharing one SIE transmit interface
// among several packet sources.
module usb_tx_arbiter
  import config_pkg::*;
#(
  parameter int REQUESTERS = 2
) (
  input  logic                    clk48,
  input  logic                    rst,
  input  logic                    usbResetDetected,
  input  logic                    isSendingPhase,
  input  logic [REQUESTERS-1:0]   reqSend,
  input  logic [REQUESTERS-1:0]   reqDataValid,
  input  logic [REQUESTERS-1:0]   reqIsLastByte,
  input  logic [8*REQUESTERS-1:0] reqData,
  output logic [REQUESTERS-1:0]   reqGrant,
  output logic [REQUESTERS-1:0]   reqAcceptNewData,
  output logic [REQUESTERS-1:0]   reqPacketDone,
  output logic                    reqAborted,
  output logic                    txReqSendPacket,
  output logic                    txDataValid,
  output logic                    txIsLastByte,
  output logic [7:0]              txData,
  input  logic                    txAcceptNewData
);

  localparam int PTR_W = ptr_width(REQUESTERS);

  tx_state_e               r_state;
  tx_state_e               w_nextState;
  logic [REQUESTERS-1:0]   r_grant;
  logic [REQUESTERS-1:0]   r_packetDone;
  logic                    r_aborted;
  logic [PTR_W-1:0]        r_rrPtr;
  logic                    r_seenSending;
  logic [REQUESTERS-1:0]   w_selGrant;
  logic [REQUESTERS-1:0]   w_routeMask;
  logic [PTR_W-1:0]        w_nextPtr;
  logic                    w_start;
  logic                    w_abort;
  logic                    w_finish;
  logic                    w_lastXfer;

  rr_priority_select #(
    .N     (REQUESTERS),
    .PTR_W (PTR_W)
  ) u_rr_select (
    .i_req   (reqSend),
    .i_ptr   (r_rrPtr),
    .o_grant (w_selGrant)
  );

  assign w_start    = (r_state == ST_IDLE) && !usbResetDetected && (|reqSend);
  assign w_abort    = (r_state != ST_IDLE) && usbResetDetected;
  assign w_finish   = (r_state == ST_DRAIN) && !usbResetDetected &&
                      r_seenSending && !isSendingPhase;
  assign w_lastXfer = txDataValid && txAcceptNewData && txIsLastByte;

  // The byte path is open only in STREAM and only toward the granted source.
  assign w_routeMask      = (r_state == ST_STREAM) ? r_grant : '0;
  assign txDataValid      = |(reqDataValid & w_routeMask);
  assign txIsLastByte     = |(reqIsLastByte & w_routeMask);
  assign reqAcceptNewData = w_routeMask & {REQUESTERS{txAcceptNewData}};
  assign txReqSendPacket  = (r_state == ST_REQUEST);
  assign reqGrant         = r_grant;
  assign reqPacketDone    = r_packetDone;
  assign reqAborted       = r_aborted;

  // Byte mux: grant is one-hot, so OR-ing the masked lanes selects one.
  always_comb begin
    txData = 8'h00;
    for (int j = 0; j < REQUESTERS; j++) begin
      txData = txData | (reqData[8*j +: 8] & {8{w_routeMask[j]}});
    end
  end

  // Pointer value following the current owner, wrapping at REQUESTERS.
  always_comb begin
    w_nextPtr = '0;
    for (int j = 0; j < REQUESTERS; j++) begin
      w_nextPtr = w_nextPtr | ({PTR_W{r_grant[j]}} & PTR_W'((j + 1) % REQUESTERS));
    end
  end

  // Next-state logic; a bus reset outside IDLE always wins.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_start) w_nextState = ST_REQUEST;
        else         w_nextState = ST_IDLE;
      end
      ST_REQUEST: begin
        if (usbResetDetected) w_nextState = ST_IDLE;
        else                  w_nextState = ST_STREAM;
      end
      ST_STREAM: begin
        if (usbResetDetected) w_nextState = ST_IDLE;
        else if (w_lastXfer)  w_nextState = ST_DRAIN;
        else                  w_nextState = ST_STREAM;
      end
      ST_DRAIN: begin
        if (usbResetDetected) w_nextState = ST_IDLE;
        else if (w_finish)    w_nextState = ST_IDLE;
        else                  w_nextState = ST_DRAIN;
      end
      default: w_nextState = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk48) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_nextState;
  end

  // Grant ownership; the pointer only advances on a completed packet.
  always_ff @(posedge clk48) begin
    if (rst) begin
      r_grant <= '0;
      r_rrPtr <= '0;
    end else if (w_start) begin
      r_grant <= w_selGrant;
    end else if (w_finish) begin
      r_grant <= '0;
      r_rrPtr <= w_nextPtr;
    end else if (w_abort) begin
      r_grant <= '0;
    end
  end

  // Remembers that the SIE entered its sending phase for this packet.
  always_ff @(posedge clk48) begin
    if (rst)                                            r_seenSending <= 1'b0;
    else if (w_nextState == ST_IDLE)                    r_seenSending <= 1'b0;
    else if ((r_state != ST_IDLE) && isSendingPhase)    r_seenSending <= 1'b1;
  end

  // Completion and abort pulses, one cycle each.
  always_ff @(posedge clk48) begin
    if (rst) begin
      r_packetDone <= '0;
      r_aborted    <= 1'b0;
    end else begin
      r_packetDone <= w_finish ? r_grant : '0;
      r_aborted    <= w_abort && (|r_grant);
    end
  end

endmodule

// File: tb/tb_usb_tx_arbiter.sv
// Randomized bench for usb_tx_arbiter: requesters and SIE are emulated here and
// every output is compared each cycle against a packet-level reference model.
module tb_usb_tx_arbiter;

  localparam int N      = 3;
  localparam int CYCLES = 4000;

  logic           clk48 = 1'b0;
  logic           rst;
  logic           usbResetDetected;
  logic           isSendingPhase;
  logic [N-1:0]   reqSend;
  logic [N-1:0]   reqDataValid;
  logic [N-1:0]   reqIsLastByte;
  logic [8*N-1:0] reqData;
  logic [N-1:0]   reqGrant;
  logic [N-1:0]   reqAcceptNewData;
  logic [N-1:0]   reqPacketDone;
  logic           reqAborted;
  logic           txReqSendPacket;
  logic           txDataValid;
  logic           txIsLastByte;
  logic [7:0]     txData;
  logic           txAcceptNewData;

  int n_tests = 0;
  int n_fail  = 0;

  // Requester-side packet storage
  logic [7:0] pkt [N][8];
  int         len [N];
  int         pos [N];
  bit         has_pkt [N];

  // Reference model: owner index (-1 = none), packet progress, pointer
  int         m_owner;
  int         m_ptr;
  int         m_left;
  int         m_tail;
  bit         m_first;
  bit         m_seen;
  logic [N-1:0] m_done;
  bit         m_abort;
  int         grants [N];

  usb_tx_arbiter #(.REQUESTERS(N)) dut (
    .clk48            (clk48),
    .rst              (rst),
    .usbResetDetected (usbResetDetected),
    .isSendingPhase   (isSendingPhase),
    .reqSend          (reqSend),
    .reqDataValid     (reqDataValid),
    .reqIsLastByte    (reqIsLastByte),
    .reqData          (reqData),
    .reqGrant         (reqGrant),
    .reqAcceptNewData (reqAcceptNewData),
    .reqPacketDone    (reqPacketDone),
    .reqAborted       (reqAborted),
    .txReqSendPacket  (txReqSendPacket),
    .txDataValid      (txDataValid),
    .txIsLastByte     (txIsLastByte),
    .txData           (txData),
    .txAcceptNewData  (txAcceptNewData)
  );

  always #5 clk48 = ~clk48;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic bit_of(input logic [N-1:0] v, input int idx);
    logic [N-1:0] t;
    t = v >> idx;
    return t[0];
  endfunction

  function automatic logic [N-1:0] onehot(input int idx);
    logic [N-1:0] one;
    one = 1;
    return (idx < 0) ? '0 : (one << idx);
  endfunction

  // Round-robin choice: first requesting index at or after ptr, wrapping.
  function automatic int rr_pick(input int ptr, input logic [N-1:0] req);
    for (int k = 0; k < N; k++) begin
      if (bit_of(req, (ptr + k) % N)) return (ptr + k) % N;
    end
    return -1;
  endfunction

  task automatic drive_inputs(input int cyc);
    rst              = (cyc > 8) && ($urandom_range(0, 299) == 0);
    usbResetDetected = ($urandom_range(0, 39) == 0);
    txAcceptNewData  = ($urandom_range(0, 9) < 6);
    if (m_owner < 0)      isSendingPhase = 1'b0;
    else if (m_first)     isSendingPhase = 1'($urandom_range(0, 1));
    else if (m_left > 0)  isSendingPhase = 1'b1;
    else                  isSendingPhase = (m_tail > 0);
    for (int i = 0; i < N; i++) begin
      if (!has_pkt[i] && ($urandom_range(0, 2) == 0)) begin
        has_pkt[i] = 1'b1;
        len[i]     = $urandom_range(1, 6);
        pos[i]     = 0;
        for (int b = 0; b < 8; b++) pkt[i][b] = 8'($urandom);
      end
      // the owner may drop its request mid-packet; the grant must hold
      reqSend[i]       = has_pkt[i] && !((m_owner == i) && !m_first && ($urandom_range(0, 3) == 0));
      reqDataValid[i]  = has_pkt[i] && ($urandom_range(0, 3) != 0);
      reqIsLastByte[i] = has_pkt[i] && (pos[i] == len[i] - 1);
      reqData[8*i +: 8] = has_pkt[i] ? pkt[i][pos[i]] : 8'h00;
    end
  endtask

  task automatic check_outputs();
    bit             streaming;
    logic [N-1:0]   exp_grant;
    logic [8*N-1:0] sh;
    streaming = (m_owner >= 0) && !m_first && (m_left > 0);
    exp_grant = onehot(m_owner);
    sh        = reqData >> (8 * ((m_owner < 0) ? 0 : m_owner));
    check_eq("reqGrant", 32'(reqGrant), 32'(exp_grant));
    check_eq("txReqSendPacket", 32'(txReqSendPacket), 32'((m_owner >= 0) && m_first));
    check_eq("txDataValid", 32'(txDataValid), 32'(streaming && bit_of(reqDataValid, m_owner)));
    check_eq("txIsLastByte", 32'(txIsLastByte), 32'(streaming && bit_of(reqIsLastByte, m_owner)));
    check_eq("txData", 32'(txData), streaming ? 32'(sh[7:0]) : 32'h0);
    check_eq("reqAcceptNewData", 32'(reqAcceptNewData),
             (streaming && txAcceptNewData) ? 32'(exp_grant) : 32'h0);
    check_eq("reqPacketDone", 32'(reqPacketDone), 32'(m_done));
    check_eq("reqAborted", 32'(reqAborted), 32'(m_abort));
  endtask

  // Requesters advance their byte pointer on their own accept handshake.
  task automatic update_requesters();
    for (int i = 0; i < N; i++) begin
      if (has_pkt[i] && bit_of(reqAcceptNewData, i) && bit_of(reqDataValid, i) && (pos[i] < len[i]))
        pos[i]++;
    end
  endtask

  task automatic update_model();
    logic [N-1:0] nd;
    bit           na;
    nd = '0;
    na = 1'b0;
    if (rst) begin
      if (m_owner >= 0) has_pkt[m_owner] = 1'b0;
      m_owner = -1;
      m_ptr   = 0;
    end else if (m_owner < 0) begin
      if (!usbResetDetected && (reqSend != '0)) begin
        m_owner = rr_pick(m_ptr, reqSend);
        m_first = 1'b1;
        m_left  = len[m_owner];
        m_seen  = 1'b0;
        grants[m_owner]++;
      end
    end else if (usbResetDetected) begin
      na = 1'b1;
      has_pkt[m_owner] = 1'b0;
      m_owner = -1;
    end else if (m_first) begin
      m_first = 1'b0;
      if (isSendingPhase) m_seen = 1'b1;
    end else if (m_left > 0) begin
      if (isSendingPhase) m_seen = 1'b1;
      if (bit_of(reqDataValid, m_owner) && txAcceptNewData) begin
        m_left--;
        if (m_left == 0) m_tail = $urandom_range(0, 3);
      end
    end else begin
      if (m_seen && !isSendingPhase) begin
        nd = onehot(m_owner);
        check_eq("bytes_delivered", 32'(pos[m_owner]), 32'(len[m_owner]));
        has_pkt[m_owner] = 1'b0;
        m_ptr   = (m_owner + 1) % N;
        m_owner = -1;
      end else begin
        if (isSendingPhase) m_seen = 1'b1;
        if (m_tail > 0) m_tail--;
      end
    end
    m_done  = nd;
    m_abort = na;
  endtask

  initial begin
    m_owner = -1;
    m_ptr   = 0;
    m_left  = 0;
    m_tail  = 0;
    m_first = 1'b0;
    m_seen  = 1'b0;
    m_done  = '0;
    m_abort = 1'b0;
    for (int i = 0; i < N; i++) begin
      has_pkt[i] = 1'b0;
      len[i]     = 1;
      pos[i]     = 0;
      grants[i]  = 0;
    end
    rst              = 1'b1;
    usbResetDetected = 1'b0;
    isSendingPhase   = 1'b0;
    txAcceptNewData  = 1'b0;
    reqSend          = '0;
    reqDataValid     = '0;
    reqIsLastByte    = '0;
    reqData          = '0;
    repeat (3) @(posedge clk48);
    for (int c = 0; c < CYCLES; c++) begin
      @(posedge clk48);
      #1;
      drive_inputs(c);
      @(negedge clk48);
      check_outputs();
      update_requesters();
      update_model();
    end
    // every requester must have been served under sustained random load
    for (int i = 0; i < N; i++) check_eq("served", 32'(grants[i] > 0), 32'h1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/usb_tx_arbiter.md
USB_TX_ARBITER -- requirements
Module: usb_tx_arbiter

Interface
REQ-001 Parameter REQUESTERS, default 2, number of packet sources sharing the SIE transmit interface (range 2..8).
REQ-002 clk48  input  1  sole clock; all logic is synchronous to its rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 usbResetDetected  input  1  SIE bus-reset indication; aborts any transfer in progress.
REQ-005 isSendingPhase  input  1  SIE state; high while the SIE is transmitting a packet.
REQ-006 reqSend  input  REQUESTERS  per-requester level request to send one packet.
REQ-007 reqDataValid  input  REQUESTERS  per-requester txData valid.
REQ-008 reqIsLastByte  input  REQUESTERS  per-requester last-byte flag.
REQ-009 reqData  input  8*REQUESTERS  per-requester byte; requester i occupies bits [8i+7:8i].
REQ-010 reqGrant  output  REQUESTERS  one-hot; the requester that owns the transmit path.
REQ-011 reqAcceptNewData  output  REQUESTERS  txAcceptNewData routed to the granted requester only.
REQ-012 reqPacketDone  output  REQUESTERS  one-cycle pulse when the granted packet has left the SIE.
REQ-013 reqAborted  output  1  one-cycle pulse when a granted packet is aborted by usbResetDetected.
REQ-014 txReqSendPacket, txDataValid, txIsLastByte  output  1 each; SIE transmit controls.
REQ-015 txData  output  8; SIE transmit byte.
REQ-016 txAcceptNewData  input  1; SIE ready for the next byte.

Function
REQ-017 States: IDLE, REQUEST, STREAM, DRAIN.
REQ-018 IDLE: when reqSend is non-zero, select a requester round-robin starting at pointer rrPtr, register reqGrant, go to REQUEST; grant becomes visible one cycle after reqSend is sampled.
REQ-019 REQUEST: assert txReqSendPacket for exactly one cycle, then go to STREAM.
REQ-020 STREAM: drive txDataValid, txIsLastByte and txData from the granted requester; forward txAcceptNewData to its reqAcceptNewData bit; a byte transfers when txDataValid and txAcceptNewData are both high.
REQ-021 A transfer with txIsLastByte high moves the state to DRAIN on the next cycle.
REQ-022 DRAIN: wait until isSendingPhase is sampled low after having been seen high in REQUEST, STREAM or DRAIN; then pulse reqPacketDone for the granted requester, set rrPtr to granted index+1 (modulo REQUESTERS), clear reqGrant and return to IDLE.
REQ-023 Grant is packet-atomic: reqSend changes, including deassertion by the granted requester, are ignored outside IDLE.
REQ-024 Outside STREAM, txDataValid, txIsLastByte and txData are 0 and all reqAcceptNewData bits are 0.
REQ-025 A requester that is not granted never sees reqAcceptNewData high.
REQ-026 Round-robin fairness: with all requesters continuously requesting, grants rotate in index order and no requester waits more than REQUESTERS-1 packets.
REQ-027 usbResetDetected high in any state other than IDLE: next state is IDLE and grant is cleared; pulse reqAborted if a grant was held; no reqPacketDone is issued; rrPtr is unchanged.
REQ-028 usbResetDetected high in IDLE blocks new grants for that cycle.
REQ-029 Back-to-back packets: the earliest new grant is in the cycle after reqPacketDone (one IDLE cycle minimum).

Reset
REQ-030 rst sampled high: state IDLE, rrPtr 0, reqGrant 0, all outputs 0, no pulses.
REQ-031 rst mid-packet takes effect on the next edge, with no reqPacketDone and no reqAborted.

Structure
REQ-032 The state enum typedef and the REQUESTERS upper bound constant belong in config_pkg.
REQ-033 The round-robin selection is one sub-module, rr_priority_select (request vector and pointer in, one-hot grant out, combinational).
REQ-034 Expected size is 150-300 lines; no memories; all state is in flops.

Verification
REQ-035 reqSend=2'b01, data 0xC3,0x11 (last) -> grant 01 at t+1, txReqSendPacket one cycle, txData 0xC3 then 0x11, reqPacketDone[0] after isSendingPhase falls.
REQ-036 reqSend=2'b11 held for 4 packets -> grant order 0,1,0,1, with reqPacketDone matching each grant.
REQ-037 Grant 1 held, txAcceptNewData low for 5 cycles -> txData stable, reqAcceptNewData=00, no byte lost.
REQ-038 usbResetDetected asserted in STREAM after 2 bytes -> IDLE next cycle, reqAborted=1 for one cycle, reqPacketDone=0, rrPtr unchanged.
REQ-039 rst asserted in DRAIN -> all outputs 0 next cycle, a subsequent reqSend=2'b10 granted to requester 1 in order after requester 0 (rrPtr=0).
REQ-040 Granted requester drops reqSend in STREAM -> grant held until the packet completes or usbResetDetected.
